// File: rtl/rvfpm_xif_pkg.sv
// Shared types and constants for the rvfpm XIF offload path.
// The payload structs are sized for the default ID width and XLEN.
package rvfpm_xif_pkg;

  localparam int unsigned X_ID_WIDTH_DEFAULT = 4;
  localparam int unsigned XLEN_DEFAULT       = 32;
  localparam int unsigned REG_ADDR_W         = 5;
  localparam int unsigned INSTR_W            = 32;

  typedef enum logic [0:0] {IDLE, ISSUE} offload_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0]            instr;
    logic [X_ID_WIDTH_DEFAULT-1:0] id;
    logic [XLEN_DEFAULT-1:0]       rs1;
  } xif_issue_t;

  typedef struct packed {
    logic [X_ID_WIDTH_DEFAULT-1:0] id;
    logic [XLEN_DEFAULT-1:0]       data;
    logic [REG_ADDR_W-1:0]         rd;
    logic                          we;
  } xif_result_t;

endpackage

// File: rtl/rvfpm_id_scoreboard.sv
// Outstanding-ID scoreboard: one busy bit per transaction ID plus an in-flight counter.
// A set and a clear may land in the same cycle; the caller guarantees they name different IDs.
module rvfpm_id_scoreboard #(
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned CntW           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  ck,
  input  logic                  reset,
  input  logic                  set_i,
  input  logic [X_ID_WIDTH-1:0] set_id_i,
  input  logic                  clr_i,
  input  logic [X_ID_WIDTH-1:0] clr_id_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  output logic                  issue_busy_o,
  input  logic [X_ID_WIDTH-1:0] result_id_i,
  output logic                  result_busy_o,
  output logic                  full_o,
  output logic [CntW-1:0]       count_o
);

  localparam int unsigned NumIds = 2 ** X_ID_WIDTH;

  logic [NumIds-1:0] busy_q, busy_d;
  logic [CntW-1:0]   count_q, count_d;

  // Next busy vector and count from this cycle's set/clear requests.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_id_i] = 1'b0;
    if (set_i) busy_d[set_id_i] = 1'b1;
    count_d = count_q + CntW'(set_i) - CntW'(clr_i);
  end

  // State registers, synchronous reset.
  always_ff @(posedge ck) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign issue_busy_o  = busy_q[issue_id_i];
  assign result_busy_o = busy_q[result_id_i];
  assign full_o        = (count_q == CntW'(MAX_OUTSTANDING));
  assign count_o       = count_q;

endmodule

// File: rtl/rvfpm_xif_offloader.sv
// Core-side CORE-V-XIF style offloader into the rvfpm FPU model: assigns IDs, drives the
// issue handshake, tracks outstanding IDs and forwards results to integer writeback.
// Optional watchdog: define RVFPM_XIF_TIMEOUT_EN to add the sticky `timeout` output.
module rvfpm_xif_offloader
  import rvfpm_xif_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH      = X_ID_WIDTH_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned XLEN            = XLEN_DEFAULT
`ifdef RVFPM_XIF_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                                 ck,
  input  logic                                 reset,
  input  logic                                 instr_valid,
  output logic                                 instr_ready,
  input  logic [INSTR_W-1:0]                   instr,
  input  logic [XLEN-1:0]                      rs1_data,
  output logic                                 x_issue_valid,
  input  logic                                 x_issue_ready,
  output logic [INSTR_W-1:0]                   x_issue_instr,
  output logic [X_ID_WIDTH-1:0]                x_issue_id,
  output logic [XLEN-1:0]                      x_issue_rs1,
  input  logic                                 x_issue_accept,
  input  logic                                 x_result_valid,
  output logic                                 x_result_ready,
  input  logic [X_ID_WIDTH-1:0]                x_result_id,
  input  logic [XLEN-1:0]                      x_result_data,
  input  logic [REG_ADDR_W-1:0]                x_result_rd,
  input  logic                                 x_result_we,
  output logic                                 wb_valid,
  output logic [REG_ADDR_W-1:0]                wb_rd,
  output logic [XLEN-1:0]                      wb_data,
  output logic                                 illegal_instr,
  output logic                                 spurious_result,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt
`ifdef RVFPM_XIF_TIMEOUT_EN
  , output logic                               timeout
`endif
);

  offload_state_e          state_q, state_d;
  xif_issue_t              issue_q, issue_d;
  xif_result_t             res;
  logic [X_ID_WIDTH-1:0]   next_id_q, next_id_d;
  logic                    illegal_q, illegal_d;
  logic                    spurious_q, spurious_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0]   wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]         wb_data_q, wb_data_d;
  logic                    sb_set, sb_clr, sb_full, sb_issue_busy, sb_result_busy, res_hs;

  rvfpm_id_scoreboard #(
    .X_ID_WIDTH      (X_ID_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard (
    .ck            (ck),
    .reset         (reset),
    .set_i         (sb_set),
    .set_id_i      (issue_q.id),
    .clr_i         (sb_clr),
    .clr_id_i      (x_result_id),
    .issue_id_i    (next_id_q),
    .issue_busy_o  (sb_issue_busy),
    .result_id_i   (x_result_id),
    .result_busy_o (sb_result_busy),
    .full_o        (sb_full),
    .count_o       (outstanding_cnt)
  );

  // Issue FSM: take an instruction in IDLE, hold the payload in ISSUE until the coprocessor answers.
  always_comb begin
    state_d       = state_q;
    issue_d       = issue_q;
    next_id_d     = next_id_q;
    illegal_d     = 1'b0;
    sb_set        = 1'b0;
    instr_ready   = 1'b0;
    x_issue_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The next ID must be free as well: after a wrap it may still be in flight.
        instr_ready = ~reset & ~sb_full & ~sb_issue_busy;
        if (instr_valid && instr_ready) begin
          issue_d.instr = instr;
          issue_d.id    = next_id_q;
          issue_d.rs1   = rs1_data;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        x_issue_valid = 1'b1;
        if (x_issue_ready) begin
          state_d = IDLE;
          if (x_issue_accept) begin
            sb_set    = 1'b1;
            next_id_d = next_id_q + 1'b1;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result path: retire known IDs, flag unknown ones, stage a one-cycle writeback.
  always_comb begin
    res        = '{id: x_result_id, data: x_result_data, rd: x_result_rd, we: x_result_we};
    res_hs     = x_result_valid & x_result_ready;
    sb_clr     = res_hs & sb_result_busy;
    spurious_d = res_hs & ~sb_result_busy;
    // x0 is never written even though the result still retires.
    wb_valid_d = sb_clr & res.we & (res.rd != '0);
    wb_rd_d    = wb_valid_d ? res.rd : '0;
    wb_data_d  = wb_valid_d ? res.data : '0;
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge ck) begin
    if (reset) begin
      state_q    <= IDLE;
      issue_q    <= '0;
      next_id_q  <= '0;
      illegal_q  <= 1'b0;
      spurious_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      issue_q    <= issue_d;
      next_id_q  <= next_id_d;
      illegal_q  <= illegal_d;
      spurious_q <= spurious_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign x_result_ready  = ~reset;
  assign x_issue_instr   = issue_q.instr;
  assign x_issue_id      = issue_q.id;
  assign x_issue_rs1     = issue_q.rs1;
  assign illegal_instr   = illegal_q;
  assign spurious_result = spurious_q;
  assign wb_valid        = wb_valid_q;
  assign wb_rd           = wb_rd_q;
  assign wb_data         = wb_data_q;

`ifdef RVFPM_XIF_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            timeout_q, timeout_d;

  // Watchdog: count cycles without a retire while anything is in flight; sticky once tripped.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (sb_clr || (outstanding_cnt == '0)) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TmoW'(TIMEOUT_CYCLES)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES));
  end

  // Watchdog registers, synchronous reset.
  always_ff @(posedge ck) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_rvfpm_xif_offloader.sv
// Self-checking bench for rvfpm_xif_offloader: directed scenarios plus a randomized phase,
// all compared against a transaction-level model (set of in-flight IDs, next ID counter).
module tb_rvfpm_xif_offloader;

  localparam int NIDS = 16;
  localparam int MAXO = 8;

  logic        ck = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs1_data = '0;
  logic        x_issue_valid;
  logic        x_issue_ready = 1'b0;
  logic [31:0] x_issue_instr;
  logic [3:0]  x_issue_id;
  logic [31:0] x_issue_rs1;
  logic        x_issue_accept = 1'b0;
  logic        x_result_valid = 1'b0;
  logic        x_result_ready;
  logic [3:0]  x_result_id = '0;
  logic [31:0] x_result_data = '0;
  logic [4:0]  x_result_rd = '0;
  logic        x_result_we = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal_instr;
  logic        spurious_result;
  logic [3:0]  outstanding_cnt;
`ifdef RVFPM_XIF_TIMEOUT_EN
  logic        timeout;
`endif

  rvfpm_xif_offloader dut (
    .ck              (ck),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .rs1_data        (rs1_data),
    .x_issue_valid   (x_issue_valid),
    .x_issue_ready   (x_issue_ready),
    .x_issue_instr   (x_issue_instr),
    .x_issue_id      (x_issue_id),
    .x_issue_rs1     (x_issue_rs1),
    .x_issue_accept  (x_issue_accept),
    .x_result_valid  (x_result_valid),
    .x_result_ready  (x_result_ready),
    .x_result_id     (x_result_id),
    .x_result_data   (x_result_data),
    .x_result_rd     (x_result_rd),
    .x_result_we     (x_result_we),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .illegal_instr   (illegal_instr),
    .spurious_result (spurious_result),
    .outstanding_cnt (outstanding_cnt)
`ifdef RVFPM_XIF_TIMEOUT_EN
    , .timeout       (timeout)
`endif
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the set of in-flight IDs and the ID the next accepted issue will carry.
  bit outstanding[int];
  int model_next = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  function automatic bit model_ready();
    return (outstanding.num() < MAXO) && !outstanding.exists(model_next);
  endfunction

  function automatic int pick_outstanding();
    int ids[$];
    foreach (outstanding[k]) ids.push_back(k);
    if (ids.size() == 0) return -1;
    return ids[$urandom_range(0, ids.size() - 1)];
  endfunction

  task automatic clear_inputs();
    instr_valid    = 1'b0;
    x_issue_ready  = 1'b0;
    x_issue_accept = 1'b0;
    x_result_valid = 1'b0;
    x_result_we    = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    check_eq("rst_instr_ready", instr_ready, 0);
    check_eq("rst_issue_valid", x_issue_valid, 0);
    check_eq("rst_issue_id", x_issue_id, 0);
    check_eq("rst_issue_instr", x_issue_instr, 0);
    check_eq("rst_result_ready", x_result_ready, 0);
    check_eq("rst_wb_valid", wb_valid, 0);
    check_eq("rst_illegal", illegal_instr, 0);
    check_eq("rst_spurious", spurious_result, 0);
    check_eq("rst_cnt", outstanding_cnt, 0);
    reset = 1'b0;
    outstanding.delete();
    model_next = 0;
    tick();
  endtask

  // One instruction through the issue handshake; optionally a result lands in the decision cycle.
  task automatic issue_one(input logic [31:0] ins, input logic [31:0] rs, input bit acc,
                           input int stall, input int res_id);
    int          id_exp = model_next;
    bit          hit;
    logic [4:0]  rrd    = 5'($urandom_range(1, 31));
    logic [31:0] rdata  = $urandom;
    instr_valid = 1'b1;
    instr       = ins;
    rs1_data    = rs;
    check_eq("instr_ready_idle", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    instr       = $urandom;
    rs1_data    = $urandom;
    check_eq("issue_valid", x_issue_valid, 1);
    check_eq("issue_id", x_issue_id, id_exp);
    check_eq("issue_instr", x_issue_instr, ins);
    check_eq("issue_rs1", x_issue_rs1, rs);
    check_eq("instr_ready_in_issue", instr_ready, 0);
    for (int s = 0; s < stall; s++) begin
      tick();
      check_eq("stall_valid", x_issue_valid, 1);
      check_eq("stall_instr", x_issue_instr, ins);
      check_eq("stall_rs1", x_issue_rs1, rs);
      check_eq("stall_id", x_issue_id, id_exp);
      check_eq("stall_instr_ready", instr_ready, 0);
    end
    x_issue_ready  = 1'b1;
    x_issue_accept = acc;
    hit = (res_id >= 0) && outstanding.exists(res_id);
    if (res_id >= 0) begin
      x_result_valid = 1'b1;
      x_result_id    = 4'(res_id);
      x_result_rd    = rrd;
      x_result_data  = rdata;
      x_result_we    = 1'b1;
    end
    tick();
    clear_inputs();
    check_eq("illegal_pulse", illegal_instr, !acc);
    check_eq("issue_released", x_issue_valid, 0);
    check_eq("sim_wb_valid", wb_valid, hit);
    if (hit) begin
      check_eq("sim_wb_rd", wb_rd, rrd);
      check_eq("sim_wb_data", wb_data, rdata);
      outstanding.delete(res_id);
    end
    check_eq("issue_spurious", spurious_result, (res_id >= 0) && !hit);
    if (acc) begin
      outstanding[id_exp] = 1'b1;
      model_next = (model_next + 1) % NIDS;
    end
    check_eq("issue_cnt", outstanding_cnt, outstanding.num());
  endtask

  task automatic send_result(input int id, input int rd, input logic [31:0] data, input bit we);
    bit hit    = outstanding.exists(id);
    bit exp_wb = hit && we && (rd != 0);
    x_result_valid = 1'b1;
    x_result_id    = 4'(id);
    x_result_rd    = 5'(rd);
    x_result_data  = data;
    x_result_we    = we;
    check_eq("result_ready", x_result_ready, 1);
    tick();
    x_result_valid = 1'b0;
    x_result_we    = 1'b0;
    check_eq("wb_valid", wb_valid, exp_wb);
    if (exp_wb) begin
      check_eq("wb_rd", wb_rd, rd);
      check_eq("wb_data", wb_data, data);
    end
    check_eq("spurious", spurious_result, !hit);
    if (hit) outstanding.delete(id);
    check_eq("result_cnt", outstanding_cnt, outstanding.num());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int prior;
    int rid;

    apply_reset();

    // Single accepted issue, then its result with writeback.
    issue_one(32'h0020F053, 32'h5, 1'b1, 0, -1);
    send_result(0, 3, 32'hDEAD, 1'b1);
    tick();
    check_eq("wb_one_cycle", wb_valid, 0);

    // Rejected issue does not consume an ID.
    apply_reset();
    issue_one($urandom, $urandom, 1'b0, 0, -1);
    tick();
    check_eq("illegal_one_cycle", illegal_instr, 0);
    issue_one($urandom, $urandom, 1'b1, 1, -1);
    send_result(0, 0, $urandom, 1'b1);   // rd = x0 retires without writeback
    send_result(7, 5, $urandom, 1'b1);   // nothing outstanding
    tick();
    check_eq("spurious_one_cycle", spurious_result, 0);

    // Backpressure, then fill to the limit.
    apply_reset();
    issue_one($urandom, $urandom, 1'b1, 5, -1);
    for (int k = 1; k < MAXO; k++) issue_one($urandom, $urandom, 1'b1, $urandom_range(0, 2), -1);
    instr_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check_eq("full_ready", instr_ready, 0);
      check_eq("full_cnt", outstanding_cnt, MAXO);
      tick();
      check_eq("full_no_issue", x_issue_valid, 0);
    end
    instr_valid = 1'b0;
    send_result(3, 9, 32'h1234_5678, 1'b1);
    check_eq("ready_after_retire", instr_ready, 1);
    issue_one($urandom, $urandom, 1'b1, 0, -1);

    // Retire and accept in the same cycle.
    send_result(pick_outstanding(), 4, $urandom, 1'b1);
    prior = outstanding.num();
    issue_one($urandom, $urandom, 1'b1, 0, pick_outstanding());
    check_eq("sim_cnt_unchanged", outstanding_cnt, prior);

    // ID wrap with ID 0 still in flight.
    apply_reset();
    for (int k = 0; k < NIDS; k++) begin
      issue_one($urandom, $urandom, 1'b1, 0, -1);
      if (k != 0) send_result(k, $urandom_range(0, 31), $urandom, 1'b1);
    end
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_eq("wrap_stall_ready", instr_ready, 0);
      tick();
      check_eq("wrap_stall_valid", x_issue_valid, 0);
    end
    instr_valid = 1'b0;
    send_result(0, 1, $urandom, 1'b1);
    issue_one($urandom, $urandom, 1'b1, 0, -1);

    // Reset with transactions in flight drops them.
    apply_reset();
    for (int k = 0; k < 3; k++) issue_one($urandom, $urandom, 1'b1, 0, -1);
    apply_reset();
    send_result(1, 2, $urandom, 1'b1);

    // Randomized mix.
    apply_reset();
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) < 5 && model_ready()) begin
        issue_one($urandom, $urandom, $urandom_range(0, 4) != 0, $urandom_range(0, 2),
                  ($urandom_range(0, 3) == 0) ? pick_outstanding() : -1);
      end else begin
        rid = pick_outstanding();
        if (rid < 0 || $urandom_range(0, 9) < 3) rid = $urandom_range(0, NIDS - 1);
        send_result(rid, $urandom_range(0, 31), $urandom, $urandom_range(0, 1) == 1);
      end
    end

`ifdef RVFPM_XIF_TIMEOUT_EN
    apply_reset();
    check_eq("tmo_reset", timeout, 0);
    issue_one($urandom, $urandom, 1'b1, 0, -1);
    repeat (250) tick();
    check_eq("tmo_not_yet", timeout, 0);
    repeat (10) tick();
    check_eq("tmo_set", timeout, 1);
    send_result(pick_outstanding(), 1, $urandom, 1'b1);
    repeat (5) tick();
    check_eq("tmo_sticky", timeout, 1);
    apply_reset();
    check_eq("tmo_cleared", timeout, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
